// File: rtl/axis_fifo_if.sv
// axistream_if: AXI4-Stream bundle shared by producers, FIFOs and consumers.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. Once the master raises tvalid it holds tvalid and every payload
// field stable until that transfer happens. tvalid never depends on tready.
//
// Signals: tvalid, tready, tdata[DWIDTH], tstrb/tkeep[DWIDTH/8], tlast,
//          tid[ID_WIDTH], tdest[DEST_WIDTH], tuser[USER_WIDTH].
// Modports: master drives payload and tvalid; slave drives tready.
interface axistream_if #(
  parameter int DWIDTH     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 6
);
  logic                    tvalid;
  logic                    tready;
  logic [DWIDTH-1:0]       tdata;
  logic [DWIDTH/8-1:0]     tstrb;
  logic [DWIDTH/8-1:0]     tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_fifo.sv
// axis_fifo: single-clock AXI4-Stream FIFO storing whole beats (all sideband
// fields). Upstream tready, downstream tvalid and downstream payload are all
// flop outputs, so no combinational path crosses the FIFO.
//
// Ports:
//   aclk       clock, rising edge
//   areset     synchronous active-high reset
//   s_axis     upstream AXI4-Stream (slave side)
//   m_axis     downstream AXI4-Stream (master side)
//   count      beats currently held (including the one on m_axis)
//   pkt_count  held beats with tlast=1 (complete packets)
module axis_fifo #(
  parameter int DWIDTH     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 6,
  parameter int DEPTH      = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  axistream_if.slave               s_axis,
  axistream_if.master              m_axis,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_count
);
  localparam int SW       = DWIDTH / 8;
  localparam int BW       = DWIDTH + 2 * SW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int LAST_BIT = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [BW-1:0] in_beat;
  logic [BW-1:0] out_q;
  logic [BW-1:0] out_nxt;
  logic          tready_q;
  logic          tvalid_q;
  logic          push;
  logic          pop;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_nxt;
  logic          pkt_inc;
  logic          pkt_dec;

  assign in_beat = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                    s_axis.tid, s_axis.tdest, s_axis.tuser};

  assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = out_q;

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = tvalid_q;

  assign push    = s_axis.tvalid & tready_q;
  assign pop     = tvalid_q & m_axis.tready;
  assign pkt_inc = push & s_axis.tlast;
  assign pkt_dec = pop & out_q[LAST_BIT];

  // out_q always mirrors the oldest stored beat, mem[rd_ptr]. After this edge
  // the head is mem[rd_ptr_nxt] if anything older than this cycle's push
  // remains; otherwise an incoming beat goes straight into out_q (it is also
  // written to mem so the pointers stay uniform). With nothing left the
  // register keeps the last popped beat.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(pop);
    remain     = count - CW'(pop);
    count_nxt  = remain + CW'(push);
    out_nxt    = out_q;
    if (remain != '0) begin
      out_nxt = mem[rd_ptr_nxt];
    end else if (push) begin
      out_nxt = in_beat;
    end
  end

  // Storage carries no reset; count gates which entries are meaningful.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= in_beat;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      tready_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      out_q     <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      pkt_count <= pkt_count + CW'(pkt_inc) - CW'(pkt_dec);
      tready_q  <= (count_nxt < DEPTH_C);
      tvalid_q  <= (count_nxt != '0);
      out_q     <= out_nxt;
    end
  end
endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed bench for axis_fifo. A DEPTH=4 instance covers reset,
// single beat, fill/full, streaming wrap and random backpressure with a
// mid-stream reset; a DEPTH=16 instance covers packet accounting.
module tb_axis_fifo;
  localparam int W = 39;  // scoreboard beat: {tdata, tlast, tuser}

  // ---------------- clock / reset ----------------
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axistream_if s4 ();
  axistream_if m4 ();
  axistream_if s16 ();
  axistream_if m16 ();
  logic [2:0] count4;
  logic [2:0] pkt4;
  logic [4:0] count16;
  logic [4:0] pkt16;

  axis_fifo #(.DEPTH(4)) dut4 (
    .aclk(aclk), .areset(areset), .s_axis(s4), .m_axis(m4),
    .count(count4), .pkt_count(pkt4)
  );

  axis_fifo #(.DEPTH(16)) dut16 (
    .aclk(aclk), .areset(areset), .s_axis(s16), .m_axis(m16),
    .count(count16), .pkt_count(pkt16)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_beat  = '0;
  logic         last_push  = 1'b0;
  int           popped     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock on dut4: score the handshakes about to happen, advance to the
  // next falling edge, where outputs are checked and inputs driven.
  task automatic cycle4();
    logic [W-1:0] b;
    if (prev_stall) begin
      check("hold_valid", 64'(m4.tvalid), 64'(1));
      check("hold_beat", 64'({m4.tdata, m4.tlast, m4.tuser}), 64'(prev_beat));
    end
    if (areset) begin
      exp_q.delete();
      prev_stall = 1'b0;
      last_push  = 1'b0;
    end else begin
      if (m4.tvalid && m4.tready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'(1), 64'(0));
        end else begin
          b = exp_q.pop_front();
          check("sb_beat", 64'({m4.tdata, m4.tlast, m4.tuser}), 64'(b));
          popped++;
        end
      end
      last_push = s4.tvalid && s4.tready;
      if (last_push) exp_q.push_back({s4.tdata, s4.tlast, s4.tuser});
      prev_stall = m4.tvalid && !m4.tready;
      prev_beat  = {m4.tdata, m4.tlast, m4.tuser};
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic cycle16();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int nvalid;
    int maxc;
    logic epoch;
    int seq;

    s4.tvalid = 1'b1; s4.tdata = 32'h55; s4.tstrb = 4'hf; s4.tkeep = 4'hf;
    s4.tlast = 1'b0; s4.tid = '0; s4.tdest = '0; s4.tuser = '0;
    m4.tready = 1'b0;
    s16.tvalid = 1'b0; s16.tdata = '0; s16.tstrb = 4'hf; s16.tkeep = 4'hf;
    s16.tlast = 1'b0; s16.tid = '0; s16.tdest = '0; s16.tuser = '0;
    m16.tready = 1'b0;
    @(negedge aclk);

    // Reset held 3 cycles with tvalid high.
    for (int i = 0; i < 3; i++) begin
      cycle4();
      check("rst_tready", 64'(s4.tready), 64'(0));
      check("rst_tvalid", 64'(m4.tvalid), 64'(0));
      check("rst_count", 64'(count4), 64'(0));
      check("rst_tdata", 64'(m4.tdata), 64'(0));
    end
    areset = 1'b0;
    s4.tvalid = 1'b0;
    cycle4();
    check("rel_tready", 64'(s4.tready), 64'(1));
    check("rel_count", 64'(count4), 64'(0));
    check("rel_tvalid", 64'(m4.tvalid), 64'(0));

    // Single beat with full sideband.
    s4.tvalid = 1'b1; s4.tdata = 32'hDEADBEEF; s4.tlast = 1'b1; s4.tid = 4'd3;
    s4.tdest = 1'b1; s4.tuser = 6'h2A; s4.tkeep = 4'h7; s4.tstrb = 4'h5;
    cycle4();
    s4.tvalid = 1'b0;
    check("one_tvalid", 64'(m4.tvalid), 64'(1));
    check("one_tdata", 64'(m4.tdata), 64'h DEADBEEF);
    check("one_tlast", 64'(m4.tlast), 64'(1));
    check("one_tid", 64'(m4.tid), 64'(3));
    check("one_tdest", 64'(m4.tdest), 64'(1));
    check("one_tuser", 64'(m4.tuser), 64'h2A);
    check("one_tkeep", 64'(m4.tkeep), 64'h7);
    check("one_tstrb", 64'(m4.tstrb), 64'h5);
    check("one_count", 64'(count4), 64'(1));
    check("one_pkt", 64'(pkt4), 64'(1));
    m4.tready = 1'b1;
    cycle4();
    m4.tready = 1'b0;
    check("one_pop_count", 64'(count4), 64'(0));
    check("one_pop_pkt", 64'(pkt4), 64'(0));
    check("one_pop_tvalid", 64'(m4.tvalid), 64'(0));
    check("one_hold_tdata", 64'(m4.tdata), 64'h DEADBEEF);

    // Fill to full with 0x1..0x6 presented one per cycle.
    s4.tid = '0; s4.tdest = '0; s4.tkeep = 4'hf; s4.tstrb = 4'hf;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      s4.tvalid = 1'b1; s4.tdata = 32'(i); s4.tlast = 1'b0; s4.tuser = '0;
      if (s4.tready) acc++;
      cycle4();
      if (i == 4) begin
        check("full_tready", 64'(s4.tready), 64'(0));
        check("full_count", 64'(count4), 64'(4));
      end
    end
    s4.tvalid = 1'b0;
    check("full_accepted", 64'(acc), 64'(4));
    check("full_still", 64'(s4.tready), 64'(0));
    for (int i = 1; i <= 4; i++) begin
      m4.tready = 1'b1;
      check("drain_tvalid", 64'(m4.tvalid), 64'(1));
      check("drain_tdata", 64'(m4.tdata), 64'(i));
      cycle4();
      if (i == 1) check("drain_tready_back", 64'(s4.tready), 64'(1));
    end
    m4.tready = 1'b0;
    check("drain_empty", 64'(m4.tvalid), 64'(0));
    check("drain_count", 64'(count4), 64'(0));

    // Streaming wrap: 40 beats, both sides always ready.
    m4.tready = 1'b1;
    popped = 0; nvalid = 0; maxc = 0;
    for (int c = 0; c < 42; c++) begin
      if (c < 40) begin
        s4.tvalid = 1'b1; s4.tdata = 32'h100 + 32'(c); s4.tlast = (c % 4 == 3);
        s4.tuser = 6'(c);
      end else begin
        s4.tvalid = 1'b0;
      end
      if (m4.tvalid) nvalid++;
      if (int'(count4) > maxc) maxc = int'(count4);
      cycle4();
    end
    check("stream_popped", 64'(popped), 64'(40));
    check("stream_valid_cycles", 64'(nvalid), 64'(40));
    check("stream_max_count", 64'(maxc), 64'(1));
    check("stream_left", 64'(exp_q.size()), 64'(0));
    m4.tready = 1'b0;

    // Packet accounting on the DEPTH=16 instance: lengths 1, 2, 5.
    for (int i = 0; i < 8; i++) begin
      s16.tvalid = 1'b1; s16.tdata = 32'(i); s16.tlast = (i == 0 || i == 2 || i == 7);
      cycle16();
    end
    s16.tvalid = 1'b0;
    check("pkt_count8", 64'(count16), 64'(8));
    check("pkt_pkts3", 64'(pkt16), 64'(3));
    m16.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("pkt_pop_data", 64'(m16.tdata), 64'(i));
      cycle16();
    end
    m16.tready = 1'b0;
    check("pkt_after3_pkts", 64'(pkt16), 64'(1));
    check("pkt_after3_count", 64'(count16), 64'(5));
    m16.tready = 1'b1;
    for (int i = 3; i < 7; i++) cycle16();
    m16.tready = 1'b0;
    check("pkt_head_data", 64'(m16.tdata), 64'(7));
    check("pkt_head_last", 64'(m16.tlast), 64'(1));
    check("pkt_head_count", 64'(count16), 64'(1));
    s16.tvalid = 1'b1; s16.tdata = 32'd8; s16.tlast = 1'b1; m16.tready = 1'b1;
    cycle16();
    s16.tvalid = 1'b0;
    check("pkt_both_pkts", 64'(pkt16), 64'(1));
    check("pkt_both_count", 64'(count16), 64'(1));
    check("pkt_both_data", 64'(m16.tdata), 64'(8));
    cycle16();
    m16.tready = 1'b0;
    check("pkt_final_pkts", 64'(pkt16), 64'(0));
    check("pkt_final_count", 64'(count16), 64'(0));

    // Random traffic with a reset at cycle 250.
    epoch = 1'b0; seq = 0; s4.tvalid = 1'b0; last_push = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (c == 250) begin
        areset = 1'b1; s4.tvalid = 1'b0; epoch = 1'b1;
      end else begin
        areset = 1'b0;
        if (!(s4.tvalid && !last_push)) begin
          s4.tvalid = 1'($urandom_range(0, 1));
          s4.tdata  = {epoch, 31'(seq)};
          s4.tlast  = 1'($urandom_range(0, 1));
          s4.tuser  = 6'($urandom_range(0, 63));
          seq++;
        end
        m4.tready = ($urandom_range(0, 3) != 0);
      end
      if (c == 251) begin
        check("mid_rst_tvalid", 64'(m4.tvalid), 64'(0));
        check("mid_rst_tready", 64'(s4.tready), 64'(0));
        check("mid_rst_count", 64'(count4), 64'(0));
        check("mid_rst_pkts", 64'(pkt4), 64'(0));
      end
      if (c > 251 && m4.tvalid) check("no_stale_beat", 64'(m4.tdata[31]), 64'(1));
      cycle4();
    end
    s4.tvalid = 1'b0;
    m4.tready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle4();
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    cycle4();
    check("rand_empty", 64'(m4.tvalid), 64'(0));
    check("rand_count", 64'(count4), 64'(0));

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
